// File: rtl/phase_detect_if.sv
// Sample/result bundle for phase_detect: edge timestamps and period in,
// signed phase result and status flags out.
interface phase_detect_if;
   logic               in_valid;
   logic [31:0]        v_edge_time;
   logic [31:0]        i_edge_time;
   logic [31:0]        v_period_time;
   logic signed [15:0] phase_diff;
   logic               i_lag;
   logic               phase_valid;
   logic               phase_err;
   logic               busy;
   logic               overrun;

   modport master (
      output in_valid, v_edge_time, i_edge_time, v_period_time,
      input  phase_diff, i_lag, phase_valid, phase_err, busy, overrun
   );

   modport slave (
      input  in_valid, v_edge_time, i_edge_time, v_period_time,
      output phase_diff, i_lag, phase_valid, phase_err, busy, overrun
   );
endinterface

// File: rtl/phase_detect.sv
// Phase of current edge relative to voltage edge in 0.1 degree units via a
// 44-cycle restoring divider. Define PHASE_AVG_EN to output a 4-sample mean.
module phase_detect (
   input logic          clk,
   input logic          rst,
   phase_detect_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, ADJ, DIV, NORM,
`ifdef PHASE_AVG_EN
      AVG,
`endif
      OUT
   } state_t;

   state_t             state, state_nx;
   logic [31:0]        v_r, i_r, per_r;
   logic [31:0]        rem;
   logic [43:0]        num;
   logic [5:0]         cnt;
   logic signed [15:0] phase_diff_r;
   logic               i_lag_r, phase_valid_r, phase_err_r, overrun_r;

   logic [31:0]        dt, dt_adj, rem_sub;
   logic [32:0]        rem_sh;
   logic               adj_err, rem_ge, busy_w, accept;
   logic [15:0]        q;
   logic signed [15:0] phase_n;

`ifdef PHASE_AVG_EN
   logic signed [15:0] hist [4];
   logic [2:0]         hist_n;
   logic signed [17:0] sum;
   logic signed [15:0] avg;
`endif

   always_comb begin
      dt      = i_r - v_r;
      dt_adj  = dt[31] ? dt + per_r : dt;
      // A still-negative dt wraps to a huge unsigned value and fails the range check.
      adj_err = (per_r == '0) || (dt_adj >= per_r);
      rem_sh  = {rem, num[43]};
      rem_ge  = rem_sh >= {1'b0, per_r};
      rem_sub = rem_sh[31:0] - per_r;
      q       = num[15:0];
      phase_n = (q < 16'd1800) ? signed'(q) : signed'(q - 16'd3600);
      busy_w  = (state != IDLE) || phase_err_r;
      accept  = bus.in_valid && !busy_w;
`ifdef PHASE_AVG_EN
      sum = {{2{hist[0][15]}}, hist[0]} + {{2{hist[1][15]}}, hist[1]}
          + {{2{hist[2][15]}}, hist[2]} + {{2{hist[3][15]}}, hist[3]};
      avg = sum[17:2];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = ADJ;
         ADJ:     state_nx = adj_err ? IDLE : DIV;
         DIV:     if (cnt == 6'd43) state_nx = NORM;
`ifdef PHASE_AVG_EN
         NORM:    state_nx = AVG;
         AVG:     state_nx = OUT;
`else
         NORM:    state_nx = OUT;
`endif
         OUT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v_r           <= '0;
         i_r           <= '0;
         per_r         <= '0;
         rem           <= '0;
         num           <= '0;
         cnt           <= '0;
         phase_diff_r  <= '0;
         i_lag_r       <= 1'b0;
         phase_valid_r <= 1'b0;
         phase_err_r   <= 1'b0;
         overrun_r     <= 1'b0;
`ifdef PHASE_AVG_EN
         for (int unsigned k = 0; k < 4; k++) hist[k] <= '0;
         hist_n <= '0;
`endif
      end else begin
         phase_valid_r <= 1'b0;
         phase_err_r   <= 1'b0;
         if (bus.in_valid && busy_w) overrun_r <= 1'b1;
         case (state)
            IDLE: if (accept) begin
               v_r   <= bus.v_edge_time;
               i_r   <= bus.i_edge_time;
               per_r <= bus.v_period_time;
            end
            ADJ: begin
               num <= 44'(dt_adj) * 44'd3600;
               rem <= '0;
               cnt <= '0;
               if (adj_err) phase_err_r <= 1'b1;
            end
            DIV: begin
               cnt <= cnt + 6'd1;
               if (rem_ge) begin
                  rem <= rem_sub;
                  num <= {num[42:0], 1'b1};
               end else begin
                  rem <= rem_sh[31:0];
                  num <= {num[42:0], 1'b0};
               end
            end
`ifdef PHASE_AVG_EN
            NORM: begin
               hist[0] <= phase_n;
               hist[1] <= hist[0];
               hist[2] <= hist[1];
               hist[3] <= hist[2];
               if (hist_n != 3'd4) hist_n <= hist_n + 3'd1;
            end
            AVG: if (hist_n == 3'd4) begin
               phase_diff_r  <= avg;
               i_lag_r       <= avg > 16'sd0;
               phase_valid_r <= 1'b1;
            end
`else
            NORM: begin
               phase_diff_r  <= phase_n;
               i_lag_r       <= phase_n > 16'sd0;
               phase_valid_r <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.phase_diff  = phase_diff_r;
   assign bus.i_lag       = i_lag_r;
   assign bus.phase_valid = phase_valid_r;
   assign bus.phase_err   = phase_err_r;
   assign bus.busy        = busy_w;
   assign bus.overrun     = overrun_r;
endmodule

// File: doc/phase_detect.md
PHASE_DETECT -- requirements
Module: phase_detect

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 in_valid  input  1  one-cycle strobe; edge/period inputs valid this cycle.
REQ-004 v_edge_time  input  32  voltage rising-edge timestamp, counter ticks, unsigned, wraps mod 2^32.
REQ-005 i_edge_time  input  32  current rising-edge timestamp, same time base.
REQ-006 v_period_time  input  32  voltage period, ticks, unsigned.
REQ-007 phase_diff  output  16  signed phase of current relative to voltage, 0.1 deg units, range -1800..+1799.
REQ-008 i_lag  output  1  1 when phase_diff > 0, meaning current lags voltage.
REQ-009 phase_valid  output  1  one-cycle pulse; phase_diff and i_lag updated this cycle.
REQ-010 phase_err  output  1  one-cycle pulse; the sample was rejected.
REQ-011 busy  output  1  high while a sample is in progress.
REQ-012 overrun  output  1  sticky; set when in_valid arrives while busy.

Function
REQ-013 FSM states: IDLE, ADJ, DIV, NORM, OUT; reset state IDLE.
REQ-014 IDLE, in_valid=1 (cycle 0):
- register all three inputs; go to ADJ.
REQ-015 ADJ (cycle 1):
- dt = i_edge_time - v_edge_time, 32-bit two's complement, treated as signed.
- if dt < 0, add v_period_time once.
- if v_period_time == 0, or adjusted dt >= v_period_time: pulse phase_err in cycle 2, hold phase_diff, return to IDLE.
- otherwise go to DIV.
REQ-016 DIV:
- numerator = dt * 3600, 44-bit unsigned.
- restoring division by v_period_time, one quotient bit per cycle, exactly 44 cycles (cycles 2..45).
- quotient q truncated, 0 <= q <= 3599.
REQ-017 NORM (cycle 46): phase = q if q < 1800, else q - 3600; sign-extend to 16 bits.
REQ-018 OUT (cycle 47): update phase_diff and i_lag, pulse phase_valid, return to IDLE.
- Fixed latency in_valid -> phase_valid: 47 cycles.
REQ-019 busy is high in cycles 1..47 of an accepted sample, including rejected samples through cycle 2.
REQ-020 in_valid while busy: sample ignored; overrun set to 1.
REQ-021 in_valid in the same cycle OUT returns to IDLE: ignored; overrun set.
REQ-022 phase_valid and phase_err never assert in the same cycle.
REQ-023 Timestamp wrap across 2^32 is handled by the modular subtraction in REQ-015; no special case.

Reset
REQ-024 rst=0 at any clock edge forces: state IDLE, phase_diff=0, i_lag=0, phase_valid=0, phase_err=0, busy=0, overrun=0, divider registers 0.
REQ-025 Reset during DIV aborts the sample; no phase_valid follows.
REQ-026 overrun is cleared only by reset.

Configuration
REQ-027 Macro PHASE_AVG_EN defined:
- output is the mean of the last 4 normalized phases: a 4-entry history with an 18-bit signed sum, divided by arithmetic shift right 2.
- one extra AVG state after NORM; latency becomes 48 cycles.
- phase_valid is suppressed until 4 samples have been accepted since reset.
- rejected samples do not enter the history.
- i_lag follows the averaged value.
REQ-028 PHASE_AVG_EN undefined: no history logic; behaviour exactly per REQ-013..REQ-023.

Verification
REQ-029 period=1000, v=5000, i=5250, in_valid -> 47 cycles later phase_valid=1, phase_diff=+900, i_lag=1.
REQ-030 period=1000, v=5000, i=4750 -> phase_diff=-900, i_lag=0; i=v=5000 -> phase_diff=0, i_lag=0.
REQ-031 period=1000, v=32'hFFFFFF00, i=32'h00000064 (dt=356) -> phase_diff=+1281.
REQ-032 period=0, or period=1000 with v=0, i=1500 -> phase_err pulse at cycle 2, no phase_valid, phase_diff unchanged.
REQ-033 second in_valid at cycle 10 of a sample -> overrun=1, first result unaffected; rst=0 at cycle 20 -> all outputs 0, no phase_valid.
REQ-034 with PHASE_AVG_EN, phases +900, +900, +1000, +1000 -> first phase_valid only after the 4th sample, phase_diff=+950.
